rtc_alarm_core: RTL

RTC_ALARM_CORE -- requirements
Module: rtc_alarm_core

---
 rtl/rtc_pkg.sv | 38 +++
 rtl/rtc_prescaler.sv | 36 +++
 rtl/rtc_alarm_core.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/rtc_pkg.sv
// Shared types, limits and hour-presentation helper for the RTC alarm core.
package rtc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } alm_state_e;

  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [4:0] HOUR_MAX = 5'd23;

  typedef struct packed {
    logic       pm;
    logic [4:0] hour;
  } hour12_t;

  // 24 h -> 12 h: midnight shows as 12 AM, noon as 12 PM.
  function automatic hour12_t to_12h(input logic [4:0] hour24);
    hour12_t r;
    if (hour24 == 5'd0) begin
      r.hour = 5'd12;
      r.pm   = 1'b0;
    end else if (hour24 < 5'd12) begin
      r.hour = hour24;
      r.pm   = 1'b0;
    end else if (hour24 == 5'd12) begin
      r.hour = 5'd12;
      r.pm   = 1'b1;
    end else begin
      r.hour = hour24 - 5'd12;
      r.pm   = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// One-second prescaler: counts 0..TICK_DIV-1 and flags the terminal cycle.
module rtc_prescaler #(
  parameter int TICK_DIV = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: wrap at terminal, restart on clear.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || (cnt_q == TERM)) begin
      cnt_d = '0;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A clear in the terminal cycle swallows that tick so a time load is never incremented.
  assign tick = (cnt_q == TERM) && !clr && !rst;

endmodule

// File: rtl/rtc_alarm_core.sv
// Real-time clock with alarm slots, snooze and ring timeout.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | no alarm active, waiting for a slot match
// ST_RING   | alarm output asserted, ring timer counting down
// ST_SNOOZE | alarm silenced, snooze timer counting down
module rtc_alarm_core
  import rtc_pkg::*;
#(
  parameter int TICK_DIV       = 100000000,
  parameter int NUM_ALM        = 2,
  parameter int SNOOZE_S       = 300,
  parameter int RING_TIMEOUT_S = 60
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         set_time,
  input  logic                                         set_alm,
  input  logic [((NUM_ALM > 1) ? $clog2(NUM_ALM) : 1)-1:0] alm_sel,
  input  logic [4:0]                                   hour_in,
  input  logic [5:0]                                   min_in,
  input  logic [5:0]                                   sec_in,
  input  logic [NUM_ALM-1:0]                           alm_en,
  input  logic                                         alm_off,
  input  logic                                         snooze,
  input  logic                                         mode12,
  output logic [4:0]                                   hour_out,
  output logic [5:0]                                   min_out,
  output logic [5:0]                                   sec_out,
  output logic                                         pm,
  output logic                                         tick,
  output logic                                         alarm,
  output logic [((NUM_ALM > 1) ? $clog2(NUM_ALM) : 1)-1:0] alm_id,
  output logic                                         set_err
);

  localparam int AW = (NUM_ALM > 1) ? $clog2(NUM_ALM) : 1;
  localparam int RW = (RING_TIMEOUT_S > 0) ? $clog2(RING_TIMEOUT_S + 1) : 1;
  localparam int SW = (SNOOZE_S > 0) ? $clog2(SNOOZE_S + 1) : 1;
  localparam logic [RW-1:0] RING_INIT = RW'(RING_TIMEOUT_S);
  localparam logic [SW-1:0] SNZ_INIT  = SW'(SNOOZE_S);

  logic [4:0]    hour_q, hour_d;
  logic [5:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic [4:0]    alm_hour_q [NUM_ALM];
  logic [5:0]    alm_min_q  [NUM_ALM];
  alm_state_e    state_q, state_d;
  logic [AW-1:0] alm_id_q, alm_id_d;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;
  logic [SW-1:0] snz_cnt_q, snz_cnt_d;
  logic          set_err_q, set_err_d;

  logic          tick_w;
  logic          time_ok, alm_ok, load_time, load_alm;
  logic          match;
  logic [AW-1:0] match_id;
  logic          en_latched;
  hour12_t       h12;

  assign time_ok   = (hour_in <= HOUR_MAX) && (min_in <= MIN_MAX) && (sec_in <= SEC_MAX);
  assign alm_ok    = (hour_in <= HOUR_MAX) && (min_in <= MIN_MAX) && (int'(alm_sel) < NUM_ALM);
  assign load_time = set_time && time_ok;
  assign load_alm  = set_alm && alm_ok;
  assign set_err_d = (set_time && !time_ok) || (set_alm && !alm_ok);

  rtc_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .clr (load_time),
    .tick(tick_w)
  );

  // Time-of-day next state: a valid load wins, otherwise increment with carries on tick.
  always_comb begin
    hour_d = hour_q;
    min_d  = min_q;
    sec_d  = sec_q;
    if (load_time) begin
      hour_d = hour_in;
      min_d  = min_in;
      sec_d  = sec_in;
    end else if (tick_w) begin
      if (sec_q == SEC_MAX) begin
        sec_d = '0;
        if (min_q == MIN_MAX) begin
          min_d  = '0;
          hour_d = (hour_q == HOUR_MAX) ? 5'd0 : hour_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end
  end

  // Slot match against the post-increment time; scanning downward leaves the lowest index.
  always_comb begin
    match    = 1'b0;
    match_id = '0;
    for (int i = NUM_ALM - 1; i >= 0; i--) begin
      if (alm_en[i] && (alm_hour_q[i] == hour_d) && (alm_min_q[i] == min_d)) begin
        match    = 1'b1;
        match_id = AW'(i);
      end
    end
    if (!tick_w || (sec_d != 6'd0)) begin
      match = 1'b0;
    end
  end

  assign en_latched = alm_en[alm_id_q];

  // Alarm FSM next state and timer updates.
  always_comb begin
    state_d    = state_q;
    alm_id_d   = alm_id_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (match) begin
          state_d    = ST_RING;
          alm_id_d   = match_id;
          ring_cnt_d = RING_INIT;
        end
      end
      ST_RING: begin
        if (alm_off || !en_latched) begin
          state_d    = ST_IDLE;
          ring_cnt_d = '0;
        end else if (snooze) begin
          state_d    = ST_SNOOZE;
          ring_cnt_d = '0;
          snz_cnt_d  = SNZ_INIT;
        end else if (tick_w) begin
          if (ring_cnt_q <= RW'(1)) begin
            state_d    = ST_IDLE;
            ring_cnt_d = '0;
          end else begin
            ring_cnt_d = ring_cnt_q - 1'b1;
          end
        end
      end
      ST_SNOOZE: begin
        if (alm_off || !en_latched) begin
          state_d   = ST_IDLE;
          snz_cnt_d = '0;
        end else if (match) begin
          state_d    = ST_RING;
          alm_id_d   = match_id;
          ring_cnt_d = RING_INIT;
          snz_cnt_d  = '0;
        end else if (tick_w) begin
          if (snz_cnt_q <= SW'(1)) begin
            state_d    = ST_RING;
            ring_cnt_d = RING_INIT;
            snz_cnt_d  = '0;
          end else begin
            snz_cnt_d = snz_cnt_q - 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All state registers; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      hour_q     <= '0;
      min_q      <= '0;
      sec_q      <= '0;
      state_q    <= ST_IDLE;
      alm_id_q   <= '0;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      set_err_q  <= 1'b0;
      for (int i = 0; i < NUM_ALM; i++) begin
        alm_hour_q[i] <= '0;
        alm_min_q[i]  <= '0;
      end
    end else begin
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      state_q    <= state_d;
      alm_id_q   <= alm_id_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      set_err_q  <= set_err_d;
      for (int i = 0; i < NUM_ALM; i++) begin
        if (load_alm && (alm_sel == AW'(i))) begin
          alm_hour_q[i] <= hour_in;
          alm_min_q[i]  <= min_in;
        end
      end
    end
  end

  assign h12      = to_12h(hour_q);
  assign hour_out = mode12 ? h12.hour : hour_q;
  assign pm       = mode12 ? h12.pm : 1'b0;
  assign min_out  = min_q;
  assign sec_out  = sec_q;
  assign tick     = tick_w;
  assign alarm    = (state_q == ST_RING);
  assign alm_id   = alm_id_q;
  assign set_err  = set_err_q;

endmodule
